// File: rtl/puf_response_collector.sv
// Sweeps the 32:1 PUF mux over two challenge banks, majority-votes each cell and
// presents the assembled 64-bit response over a valid/ready handshake.
module puf_response_collector #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned VOTES         = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [4:0]  mux_sel_o,
    output logic        bank_o,
    input  logic        mux_bit_i,
    output logic        busy_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_data_o
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > VOTES) ? SETTLE_CYCLES : VOTES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned OnesW  = $clog2(VOTES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [OnesW-1:0]   ones_q, ones_d;
    logic [63:0]        resp_q, resp_d;
    logic               valid_q, valid_d;
    logic               transfer;

    assign transfer = valid_q && resp_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        resp_d  = resp_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    cnt_d   = '0;
                    resp_d  = '0;
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    state_d = StSample;
                    cnt_d   = '0;
                    ones_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                ones_d = ones_q + OnesW'(mux_bit_i);
                if (cnt_q == CntW'(VOTES - 1)) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                resp_d[idx_q] = (ones_q > OnesW'(VOTES / 2));
                idx_d         = idx_q + 6'd1;
                cnt_d         = '0;
                state_d       = (idx_q == 6'd63) ? StDone : StSettle;
            end
            StDone: begin
                // Valid rises one cycle after DONE entry and drops on the transfer edge.
                valid_d = !transfer;
                if (transfer) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            resp_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            resp_q  <= resp_d;
            valid_q <= valid_d;
        end
    end

    assign mux_sel_o    = idx_q[4:0];
    assign bank_o       = idx_q[5];
    assign busy_o       = (state_q != StIdle);
    assign resp_valid_o = valid_q;
    assign resp_data_o  = resp_q;

endmodule
